// File: rtl/apple1_pkg.sv
// Shared types for the Apple-1 style RAM arbiter: bus owner encoding,
// DMA FSM states and the default starvation limit.
package apple1_pkg;

  // Number of consecutive denied DMA cycles before the CPU is stalled.
  localparam int STARVE_LIMIT_DEFAULT = 8;

  // Who drives the RAM port in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  // DMA side FSM: IDLE accepts a request, DMA_RD collects read data.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_DMA_RD = 1'b1
  } state_t;

  // Saturating increment used by the starvation counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] value,
                                         input logic [7:0] limit);
    return (value < limit) ? value + 8'd1 : value;
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// RAM arbiter sharing one synchronous RAM between the CPU and a DMA
// (loader/monitor) port. The CPU uses its clock-enable slots; DMA fills
// the gaps and steals one CPU slot after a run of denied cycles.
module ram_arbiter
  import apple1_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int ADDR_W       = 16
) (
  input  logic              sys_clock,
  input  logic              reset_n,
  input  logic              cpu_clken,
  output logic              cpu_enable,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic              ram_rd,
  output logic              ram_wr
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       hold_q, hold_d;
  logic [7:0] dma_rdata_q, dma_rdata_d;
  logic       dma_rvalid_q, dma_rvalid_d;
  owner_t     owner;
  logic       dma_idle_req;

  assign dma_idle_req = dma_req && (state_q == ST_IDLE);
  assign cpu_enable   = cpu_clken && !hold_q;
  assign cpu_rdata    = ram_dout;
  assign dma_rdata    = dma_rdata_q;
  assign dma_rvalid   = dma_rvalid_q;

  // Pick this cycle's RAM owner: a forced DMA slot beats the CPU, the CPU
  // beats an ordinary DMA request, and DMA never issues while a read is open.
  always_comb begin
    owner = OWN_NONE;
    if (hold_q && dma_idle_req) begin
      owner = OWN_DMA;
    end else if (cpu_clken) begin
      owner = OWN_CPU;
    end else if (dma_idle_req) begin
      owner = OWN_DMA;
    end
  end

  // RAM port mux; CPU values are the resting state so a CPU access sees no
  // added latency, and strobes are killed while reset is asserted.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_wdata;
    ram_rd   = 1'b0;
    ram_wr   = 1'b0;
    dma_ack  = 1'b0;
    case (owner)
      OWN_CPU: begin
        ram_rd = cpu_rd;
        ram_wr = cpu_wr;
      end
      OWN_DMA: begin
        ram_addr = dma_addr;
        ram_din  = dma_wdata;
        ram_rd   = !dma_we;
        ram_wr   = dma_we;
        dma_ack  = 1'b1;
      end
      default: begin
      end
    endcase
    if (!reset_n) begin
      ram_rd  = 1'b0;
      ram_wr  = 1'b0;
      dma_ack = 1'b0;
    end
  end

  // Next-state logic for the DMA FSM, read-data capture and starvation tracking.
  always_comb begin
    state_d      = state_q;
    dma_rdata_d  = dma_rdata_q;
    dma_rvalid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dma_ack && !dma_we) begin
          state_d = ST_DMA_RD;
        end
      end
      ST_DMA_RD: begin
        dma_rdata_d  = ram_dout;
        dma_rvalid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!dma_req || dma_ack) begin
      wait_cnt_d = 8'd0;
      hold_d     = 1'b0;
    end else begin
      wait_cnt_d = sat_inc(wait_cnt_q, LIMIT);
      hold_d     = hold_q || (wait_cnt_d == LIMIT);
    end
  end

  // State register with asynchronous active-low reset; a reset mid-read
  // drops the pending result.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 8'd0;
      hold_q       <= 1'b0;
      dma_rdata_q  <= 8'h00;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      hold_q       <= hold_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive denied cycles before the DMA port is forced a slot (range 1..255).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning the width of the RAM address bus.
REQ-003 sys_clock  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_clken  in  1  CPU clock-enable strobe from the clock generator.
REQ-006 cpu_enable  out  1  gated enable to the CPU core (drives its enable/ready inputs).
REQ-007 cpu_addr  in  ADDR_W, cpu_wdata in 8, cpu_rd in 1, cpu_wr in 1  CPU-side RAM request (ram_cs-qualified).
REQ-008 cpu_rdata  out  8  RAM read data to the CPU data-in mux.
REQ-009 dma_req  in  1, dma_we in 1, dma_addr in ADDR_W, dma_wdata in 8  DMA-side request (loader/monitor port).
REQ-010 dma_ack  out  1  one-cycle pulse: DMA request accepted this cycle.
REQ-011 dma_rdata  out  8, dma_rvalid out 1  DMA read data and its one-cycle qualifier.
REQ-012 ram_addr out ADDR_W, ram_din out 8, ram_dout in 8, ram_rd out 1, ram_wr out 1  synchronous RAM port (read data valid one cycle after ram_rd).

Function
REQ-013 Owner each cycle SHALL be: DMA if forced (hold_q=1) and dma_req; else CPU if cpu_clken; else DMA if dma_req and state IDLE; else none.
REQ-014 cpu_enable SHALL equal cpu_clken AND NOT hold_q (combinational).
REQ-015 CPU ownership SHALL pass cpu_addr/cpu_wdata/cpu_rd/cpu_wr combinationally to the RAM port with zero added latency.
REQ-016 cpu_rdata SHALL equal ram_dout at all times.
REQ-017 With no owner, ram_rd and ram_wr SHALL be 0 and ram_addr/ram_din SHALL hold CPU values.
REQ-018 FSM states: IDLE, DMA_RD; DMA ownership with dma_we=1 SHALL drive ram_wr=1 for exactly one cycle, pulse dma_ack, stay IDLE.
REQ-019 DMA ownership with dma_we=0 SHALL drive ram_rd=1 one cycle, pulse dma_ack, go to DMA_RD.
REQ-020 In DMA_RD the block SHALL register ram_dout into dma_rdata, pulse dma_rvalid the following cycle, and return to IDLE; no DMA grant occurs in DMA_RD (max one outstanding read).
REQ-021 DMA read latency SHALL be: dma_ack at cycle N, dma_rvalid with data at cycle N+2.
REQ-022 A CPU access SHALL be allowed in the DMA_RD cycle; dma_rdata SHALL still capture the DMA read result.
REQ-023 wait_cnt (8 bit) SHALL increment each cycle dma_req=1 and dma_ack=0, saturate at STARVE_LIMIT, clear on dma_ack or dma_req=0.
REQ-024 hold_q SHALL set on the edge where wait_cnt reaches STARVE_LIMIT and clear on the edge following dma_ack or dma_req=0.
REQ-025 dma_req dropping while hold_q=1 SHALL release hold_q without a DMA access; cpu_enable resumes next cycle.
REQ-026 DMA inputs SHALL be sampled only in the ack cycle; requester holds them stable until dma_ack.
REQ-027 cpu_clken held constantly high SHALL yield exactly one stolen CPU slot per STARVE_LIMIT+1 cycles under continuous dma_req writes.

Reset
REQ-028 reset_n low SHALL asynchronously force state=IDLE, wait_cnt=0, hold_q=0, dma_rdata=0x00, dma_rvalid=0, dma_ack=0, ram_wr=0, ram_rd=0.
REQ-029 Reset during DMA_RD SHALL discard the pending read; no dma_rvalid after release.
REQ-030 First grant after reset release SHALL follow REQ-013 in the first clock edge with reset_n high.

Structure
REQ-031 Owner encoding (NONE/CPU/DMA), FSM state enum and STARVE_LIMIT default SHALL live in shared package apple1_pkg.
REQ-032 No sub-module; single module, one sequential process for state/wait_cnt/hold_q/dma_rdata, combinational mux for RAM port.

Verification
REQ-033 cpu_clken=1 every 7th cycle, dma write 0x5A to 0x0280 -> ram_wr=1 in a non-clken cycle, dma_ack same cycle, CPU never stalled.
REQ-034 DMA read 0x0280 after write -> dma_ack at N, dma_rvalid at N+2 with dma_rdata=0x5A; CPU access in N+1 unaffected.
REQ-035 cpu_clken stuck 1, dma_req held, STARVE_LIMIT=8 -> cpu_enable=0 for exactly one cycle after 8 denied cycles, dma_ack in that cycle.
REQ-036 Forced hold active, dma_req dropped -> hold_q clears next edge, no ram_wr/ram_rd from DMA.
REQ-037 reset_n pulsed low in DMA_RD -> all outputs per REQ-028 immediately, no dma_rvalid afterwards.
REQ-038 Simultaneous cpu_clken=1 and dma_req=1, wait_cnt=0 -> CPU owns RAM, dma_ack=0, wait_cnt=1 next cycle.
